// File: rtl/pool_unit.sv
// pool_unit: streaming max-pool stage for a conv PE.
// Collects POOL_SIZE strobed conv results, pushes the window maximum into
// a small output FIFO, and backpressures the PE one slot early so that a
// result already in flight always has somewhere to land.
// Optional build macro: POOL_UNIT_RELU_EN fuses a ReLU onto the pushed max.
module pool_unit #(
    parameter int unsigned POOL_SIZE  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               start,
    input  logic signed [15:0] conv_data,
    input  logic               conv_flag,
    output logic               ready_pool,
    output logic signed [15:0] pool_out,
    output logic               pool_valid,
    input  logic               pool_ready,
    output logic               overflow
);

    localparam int unsigned CNT_W  = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam logic signed [15:0] MOST_NEG = 16'sh8000;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Window / FSM state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [15:0] max_q, max_d;
    logic signed [15:0] new_max;
    logic signed [15:0] push_val;
    logic               push;

    // FIFO state
    logic signed [15:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               ready_q, ready_d;
    logic               ovf_q, ovf_d;
    logic               pop;
    logic               full;
    logic               do_write;

    assign new_max = (conv_data > max_q) ? conv_data : max_q;

`ifdef POOL_UNIT_RELU_EN
    assign push_val = new_max[15] ? 16'sd0 : new_max;
`else
    assign push_val = new_max;
`endif

    // Window next-state: accumulate the running max and emit on the last sample
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        push    = 1'b0;
        if (!start) begin
            state_d = IDLE;
            cnt_d   = '0;
            max_d   = MOST_NEG;
        end else if (state_q == IDLE) begin
            state_d = COLLECT;
            cnt_d   = '0;
            max_d   = MOST_NEG;
        end else if (conv_flag) begin
            if (cnt_q == CNT_W'(POOL_SIZE - 1)) begin
                push  = 1'b1;
                cnt_d = '0;
                max_d = MOST_NEG;
            end else begin
                cnt_d = cnt_q + 1'b1;
                max_d = new_max;
            end
        end
    end

    // FIFO next-state: push/pop bookkeeping, sticky overflow, early backpressure
    always_comb begin
        pop      = (occ_q != '0) && pool_ready;
        full     = (occ_q == OCC_W'(FIFO_DEPTH));
        do_write = push && (!full || pop);
        ovf_d    = ovf_q | (push && full && !pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_write);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        unique case ({do_write, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        ready_d = (occ_d <= OCC_W'(FIFO_DEPTH - 2));
    end

    // Window and FSM registers
    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            max_q   <= MOST_NEG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
        end
    end

    // FIFO control registers and registered flags
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ready_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; stale entries are never visible because pool_out is gated by occupancy.
        if (do_write) begin
            mem[wr_ptr_q] <= push_val;
        end
    end

    assign pool_valid = (occ_q != '0);
    assign pool_out   = pool_valid ? mem[rd_ptr_q] : 16'sd0;
    assign ready_pool = ready_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_pool_unit.sv
// Scoreboard bench for pool_unit: stimulus pushes expected window maxima,
// a negedge monitor pops and compares whenever the DUT hands a value over.
module tb_pool_unit;

    logic               clk;
    logic               n_reset;
    logic               start;
    logic signed [15:0] conv_data;
    logic               conv_flag;
    logic               ready_pool;
    logic signed [15:0] pool_out;
    logic               pool_valid;
    logic               pool_ready;
    logic               overflow;

    int n_total = 0;
    int n_pass  = 0;

    logic signed [15:0] sb [$];

    pool_unit #(.POOL_SIZE(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .conv_data  (conv_data),
        .conv_flag  (conv_flag),
        .ready_pool (ready_pool),
        .pool_out   (pool_out),
        .pool_valid (pool_valid),
        .pool_ready (pool_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: every handover (valid & ready) is compared against the scoreboard head
    always @(negedge clk) begin
        if (n_reset && pool_valid && pool_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got %0d, expected nothing", pool_out);
            end else begin
                check("pool_out_order", pool_out, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic signed [15:0] v);
        conv_data = v;
        conv_flag = 1'b1;
        tick();
        conv_flag = 1'b0;
    endtask

    task automatic window(input logic signed [15:0] a, input logic signed [15:0] b,
                          input logic signed [15:0] c, input logic signed [15:0] d);
        strobe(a);
        strobe(b);
        strobe(c);
        strobe(d);
    endtask

    // Bounded wait for the scoreboard to empty
    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        n_reset    = 1'b0;
        start      = 1'b0;
        conv_data  = '0;
        conv_flag  = 1'b0;
        pool_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_pool_valid", pool_valid, 0);
        check("rst_ready_pool", ready_pool, 0);
        check("rst_pool_out",   pool_out,   0);
        check("rst_overflow",   overflow,   0);

        n_reset = 1'b1;
        tick();
        check("first_edge_ready", ready_pool, 1);

        // Basic window: 5,-3,12,7 -> 12, popped on the next edge
        start = 1'b1;
        tick();
        sb.push_back(16'sd12);
        window(16'sd5, -16'sd3, 16'sd12, 16'sd7);
        check("basic_valid", pool_valid, 1);
        check("basic_out",   pool_out,   12);
        tick();
        check("basic_popped", pool_valid, 0);

        // All-negative window
`ifdef POOL_UNIT_RELU_EN
        sb.push_back(16'sd0);
`else
        sb.push_back(-16'sd2);
`endif
        window(-16'sd9, -16'sd2, -16'sd20, -16'sd5);
        drain("neg_drain");

        // Fill FIFO with downstream stalled
        pool_ready = 1'b0;
        sb.push_back(16'sd4);
        window(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        sb.push_back(16'sd30);
        window(16'sd10, 16'sd30, 16'sd20, 16'sd0);
        check("ready_at_occ2", ready_pool, 1);
`ifdef POOL_UNIT_RELU_EN
        sb.push_back(16'sd0);
`else
        sb.push_back(-16'sd1);
`endif
        window(-16'sd1, -16'sd7, -16'sd3, -16'sd8);
        check("ready_at_occ3", ready_pool, 0);
        sb.push_back(16'sd200);
        window(16'sd100, 16'sd200, 16'sd50, 16'sd150);
        check("full_no_overflow", overflow, 0);
        check("full_valid", pool_valid, 1);

        // Push into full FIFO: dropped, overflow sticks
        window(16'sd7, 16'sd7, 16'sd7, 16'sd7);
        check("overflow_set", overflow, 1);
        check("head_unchanged", pool_out, 4);

        pool_ready = 1'b1;
        drain("full_drain");
        tick();
        check("drained_valid", pool_valid, 0);
        check("drained_ready", ready_pool, 1);
        check("overflow_sticky", overflow, 1);

        // Partial window discarded when start drops
        strobe(16'sd100);
        strobe(16'sd50);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        sb.push_back(16'sd4);
        window(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        drain("restart_drain");
        tick();
        check("restart_no_extra", pool_valid, 0);

        // Reset mid-window with two FIFO entries
        pool_ready = 1'b0;
        window(16'sd8, 16'sd9, 16'sd10, 16'sd11);
        window(-16'sd4, 16'sd3, 16'sd2, 16'sd1);
        check("pre_reset_valid", pool_valid, 1);
        strobe(16'sd50);
        strobe(16'sd60);
        #2;
        n_reset = 1'b0;
        #1;
        check("async_rst_valid", pool_valid, 0);
        check("async_rst_ready", ready_pool, 0);
        check("async_rst_ovf",   overflow,   0);
        pool_ready = 1'b1;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        tick();
        check("post_rst_ready", ready_pool, 1);
        sb.push_back(16'sd6);
        window(-16'sd5, 16'sd6, -16'sd7, 16'sd2);
        drain("post_rst_drain");
        tick();
        check("final_empty", pool_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
